// File: rtl/switch_index_encoder_pkg.sv
// Shared constants and state encoding for the switch index encoder.
// Widths match the 4-to-16 LED decoder so indices round-trip unchanged.
package switch_index_encoder_pkg;

    localparam int SW_W             = 16;
    localparam int IDX_W            = 4;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        SETTLE  = 2'd1,
        VALID   = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/prio_enc16.sv
// Sixteen-to-four priority encoder: highest set bit wins.
// any flags a nonzero vector, many flags more than one bit set.
module prio_enc16
    import switch_index_encoder_pkg::*;
(
    input  logic [SW_W-1:0]  in,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             many
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < SW_W; i++) begin
            if (in[i]) idx = IDX_W'(i);
        end
    end

    assign any  = |in;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign many = |(in & (in - SW_W'(1)));

endmodule

// File: rtl/switch_index_encoder.sv
// Synchronises, debounces and priority-encodes a 16-bit switch vector into a
// 4-bit index with valid/ack handshake. Optional macro: SWITCH_ENC_MULTI_REJECT_EN.
//
// state   | meaning
// ARMED   | idle, waiting for a nonzero synchronised sample while en=1
// SETTLE  | counting identical samples of the candidate vector
// VALID   | code presented, waiting for ack
// RELEASE | waiting for an all-zero vector to be stable before re-arming
module switch_index_encoder
    import switch_index_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SW_W-1:0]  SW,
    input  logic             ack,
    output logic [IDX_W-1:0] code,
    output logic             valid,
    output logic             multi,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_s;
    logic [SW_W-1:0]   cand;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  code_q;
    logic              multi_q;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;
    logic              enc_many;
    logic              sw_zero;
    logic              accept;
    logic              reject;

    prio_enc16 u_enc (
        .in   (cand),
        .idx  (enc_idx),
        .any  (enc_any),
        .many (enc_many)
    );

    assign sw_zero = (sw_s == '0);
    assign accept  = (state == SETTLE) && en && !sw_zero && (sw_s == cand)
                     && (cnt == CNT_LAST) && enc_any;

`ifdef SWITCH_ENC_MULTI_REJECT_EN
    logic err_q;

    assign reject = enc_many;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= accept && enc_many;
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state <= ARMED;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARMED: begin
                if (en && !sw_zero) state_next = SETTLE;
            end
            SETTLE: begin
                if (!en || sw_zero) state_next = ARMED;
                else if (accept)    state_next = reject ? RELEASE : VALID;
            end
            VALID: begin
                if (ack) state_next = RELEASE;
            end
            RELEASE: begin
                if (sw_zero && (cnt == CNT_LAST)) state_next = ARMED;
            end
            default: state_next = ARMED;
        endcase
    end

    always_comb begin
        valid = (state == VALID);
        code  = code_q;
        multi = multi_q;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
            cand    <= '0;
            cnt     <= '0;
            code_q  <= '0;
            multi_q <= 1'b0;
        end else begin
            sw_meta <= SW;
            sw_s    <= sw_meta;
            case (state)
                ARMED: begin
                    if (en && !sw_zero) begin
                        cand <= sw_s;
                        cnt  <= '0;
                    end
                end
                SETTLE: begin
                    if (!en || sw_zero) begin
                        cnt <= '0;
                    end else if (sw_s != cand) begin
                        cand <= sw_s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!reject) begin
                            code_q  <= enc_idx;
                            multi_q <= enc_many;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                VALID: begin
                    if (ack) begin
                        multi_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RELEASE: begin
                    if (!sw_zero || (cnt == CNT_LAST)) cnt <= '0;
                    else                               cnt <= cnt + CNT_W'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: doc/switch_index_encoder.md
Name: switch_index_encoder

Overview:
- Input-side counterpart of the 4-to-16 LED decoder: it sixteen-to-four encodes a 16-bit switch/button vector into a 4-bit index.
- Synchronises and debounces the raw switches, latches the encoded index, and presents it with a valid/ack handshake.
- Sits between the board switches and the game/mode controller, so a pressed position comes back as the same 4-bit index the counter drives into the decoder.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required to accept a press or a release. Legal range 1..255.
- CNT_W, 8: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  arm enable; while low, no new press is captured.
- SW  in  16  raw asynchronous switch vector; bit n pressed = index n.
- ack  in  1  consumer acknowledge of the current code.
- code  out  4  encoded index, held while valid=1.
- valid  out  1  code available.
- multi  out  1  more than one bit was set in the accepted vector; qualified by valid.
- err  out  1  one-cycle pulse when a multi-bit press is rejected (Optional Feature only).

Behaviour:
- Reset (reset=0, asynchronous): code=0, valid=0, multi=0, err=0, both sync flops=0, counter=0, state=ARMED.
- Synchroniser: two-flop chain on SW; sw_s is stage 2, so 2-edge latency.
- ARMED:
  - en=1 and sw_s!=0 → SETTLE; cand=sw_s, cnt=0.
  - en=0 or sw_s=0 → stay.
- SETTLE:
  - en=0 → ARMED (abort).
  - sw_s=0 → ARMED.
  - sw_s!=cand → cand=sw_s, cnt=0 (restart).
  - sw_s==cand and cnt==DEBOUNCE_CYCLES-1 → VALID; code=highest set index of cand, multi=(popcount(cand)>1).
  - Otherwise cnt++.
- VALID:
  - valid=1; code and multi frozen; SW and en are ignored.
  - ack=1 sampled → RELEASE; valid falls on that edge.
- RELEASE:
  - Waits for sw_s==0 on DEBOUNCE_CYCLES consecutive edges, then → ARMED.
  - Any nonzero sample resets cnt to 0.
  - code keeps its last value; multi is cleared.
- Latency: SW stable before edge 1 → valid high after edge DEBOUNCE_CYCLES+3 (edge 7 at the default).
- ack outside VALID: ignored.
- Priority encode: highest set bit wins, e.g. 16'h8001 → code 15, multi=1.
- One capture per press: holding a switch after ack produces no second valid until full release and re-arm.
- Reset mid-operation: returns immediately to ARMED with all outputs zeroed; a switch still held after reset deasserts is captured as a new press.

Optional Feature:
- Macro: SWITCH_ENC_MULTI_REJECT_EN.
- Defined: a SETTLE acceptance with popcount(cand)>1 produces no valid. err pulses high for exactly one cycle, and the state goes to RELEASE. multi is never 1.
- Undefined: multi-bit vectors are accepted with priority encoding and multi=1; err is tied to 0.

Decomposition:
- Shared package/include holds:
  - the state encoding: ARMED=2'd0, SETTLE=2'd1, VALID=2'd2, RELEASE=2'd3;
  - the default DEBOUNCE_CYCLES;
  - the 16/4 width constants shared with the decoder.
- One combinational sub-module, prio_enc16 (in[15:0] → idx[3:0], any, many), instantiated once.
- The FSM, synchroniser and counter stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, 1 ns Clk):
- Reset: hold reset=0 for 4 cycles with SW=16'hFFFF → code=0, valid=0, multi=0, err=0 throughout. Release reset with SW=0 → stays idle.
- Clean press: en=1, SW=16'h0020 → valid rises after edge 7 with code=5, multi=0. Holding ack=0 for 10 cycles → valid stays 1. Pulsing ack → valid falls on the next edge.
- Bounce: SW toggles 16'h0100/16'h0000 each cycle for 6 cycles, then holds 16'h0100 → exactly one valid with code=8, and no valid during the toggling.
- Hold after ack: keep SW=16'h0100 for 20 cycles after ack → no second valid. SW=0 for 4+ cycles, then 16'h0001 → new valid with code=0.
- Multi-bit: SW=16'h8004 → code=15, multi=1 with the macro undefined. With SWITCH_ENC_MULTI_REJECT_EN defined → no valid and one err pulse at edge 7.
- Disable and reset mid-operation:
  - en=0 with SW=16'h0002 → no valid.
  - en dropped mid-SETTLE → aborts with no valid.
  - reset asserted while valid=1 → valid=0 asynchronously.
